// File: rtl/l1_l2_arbiter.sv
// rtl/l1_l2_arbiter.sv - two-source (L1D/L1I) arbiter in front of a single-outstanding L2 port
//
// Ports:
//   clk, nrst                 : clock, asynchronous active-low reset
//   read_L1D_L2/write_L1D_L2  : L1D fill / writeback request levels, held until served
//   tag/index/write_* L1D     : L1D fill address, writeback address and line
//   ready_L2_L1D, read_data_L2_L1D : completion pulse and fill line back to L1D
//   read_L1I_L2, tag/index L1I     : L1I fill request level and address
//   ready_L2_L1I, read_data_L2_L1I : completion pulse and fill line back to L1I
//   read_L1_L2/write_L1_L2 and buses : request to L2, driven only while a source is granted
//   ready_L2_L1, read_data_L2_L1     : L2 completion pulse with fill data in the same cycle

module l1_l2_arbiter #(
    parameter int TNUM2         = 18,
    parameter int INUM2         = 8,
    parameter int BIT_WIDTH_low = 512
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic                     read_L1D_L2,
    input  logic                     write_L1D_L2,
    input  logic [TNUM2-1:0]         tag_L1D_L2,
    input  logic [INUM2-1:0]         index_L1D_L2,
    input  logic [TNUM2-1:0]         write_tag_L1D_L2,
    input  logic [INUM2-1:0]         write_index_L1D_L2,
    input  logic [BIT_WIDTH_low-1:0] write_data_L1D_L2,
    output logic                     ready_L2_L1D,
    output logic [BIT_WIDTH_low-1:0] read_data_L2_L1D,
    input  logic                     read_L1I_L2,
    input  logic [TNUM2-1:0]         tag_L1I_L2,
    input  logic [INUM2-1:0]         index_L1I_L2,
    output logic                     ready_L2_L1I,
    output logic [BIT_WIDTH_low-1:0] read_data_L2_L1I,
    output logic                     read_L1_L2,
    output logic                     write_L1_L2,
    output logic [TNUM2-1:0]         tag_L1_L2,
    output logic [INUM2-1:0]         index_L1_L2,
    output logic [TNUM2-1:0]         write_tag_L1_L2,
    output logic [INUM2-1:0]         write_index_L1_L2,
    output logic [BIT_WIDTH_low-1:0] write_data_L1_L2,
    input  logic                     ready_L2_L1,
    input  logic [BIT_WIDTH_low-1:0] read_data_L2_L1
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_D = 2'd1,
        GRANT_I = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t state, state_nx;
    logic   last_grant_d, last_grant_d_nx;   // 1: L1D was granted last, 0: L1I
    logic   lock, lock_nx;                   // last D grant served a writeback
    logic   d_req;

    assign d_req = read_L1D_L2 | write_L1D_L2;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            lock         <= 1'b0;
        end else begin
            state        <= state_nx;
            last_grant_d <= last_grant_d_nx;
            lock         <= lock_nx;
        end
    end

    always_comb begin
        state_nx          = state;
        last_grant_d_nx   = last_grant_d;
        lock_nx           = lock;
        ready_L2_L1D      = 1'b0;
        read_data_L2_L1D  = '0;
        ready_L2_L1I      = 1'b0;
        read_data_L2_L1I  = '0;
        read_L1_L2        = 1'b0;
        write_L1_L2       = 1'b0;
        tag_L1_L2         = '0;
        index_L1_L2       = '0;
        write_tag_L1_L2   = '0;
        write_index_L1_L2 = '0;
        write_data_L1_L2  = '0;

        case (state)
            IDLE: begin
                // A refill following a served writeback is kept atomic with it.
                if (lock && read_L1D_L2)
                    state_nx = GRANT_D;
                else if (d_req && read_L1I_L2)
                    state_nx = last_grant_d ? GRANT_I : GRANT_D;
                else if (d_req)
                    state_nx = GRANT_D;
                else if (read_L1I_L2)
                    state_nx = GRANT_I;
            end
            GRANT_D: begin
                // Writeback goes first when both are pending; the read follows
                // in a later grant once the write level has dropped.
                read_L1_L2        = read_L1D_L2 & ~write_L1D_L2;
                write_L1_L2       = write_L1D_L2;
                tag_L1_L2         = tag_L1D_L2;
                index_L1_L2       = index_L1D_L2;
                write_tag_L1_L2   = write_tag_L1D_L2;
                write_index_L1_L2 = write_index_L1D_L2;
                write_data_L1_L2  = write_data_L1D_L2;
                ready_L2_L1D      = ready_L2_L1;
                read_data_L2_L1D  = read_data_L2_L1;
                if (ready_L2_L1) begin
                    state_nx        = GAP;
                    last_grant_d_nx = 1'b1;
                    lock_nx         = write_L1D_L2;
                end
            end
            GRANT_I: begin
                read_L1_L2       = read_L1I_L2;
                tag_L1_L2        = tag_L1I_L2;
                index_L1_L2      = index_L1I_L2;
                ready_L2_L1I     = ready_L2_L1;
                read_data_L2_L1I = read_data_L2_L1;
                if (ready_L2_L1) begin
                    state_nx        = GAP;
                    last_grant_d_nx = 1'b0;
                    lock_nx         = 1'b0;
                end
            end
            GAP: begin
                // One dead cycle lets the served requester drop its level.
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// tb/tb_l1_l2_arbiter.sv - directed and randomized self-checking bench for l1_l2_arbiter

module tb_l1_l2_arbiter;

    localparam int TW = 18;
    localparam int IW = 8;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          nrst;
    logic          read_L1D_L2, write_L1D_L2;
    logic [TW-1:0] tag_L1D_L2, write_tag_L1D_L2;
    logic [IW-1:0] index_L1D_L2, write_index_L1D_L2;
    logic [DW-1:0] write_data_L1D_L2;
    logic          ready_L2_L1D;
    logic [DW-1:0] read_data_L2_L1D;
    logic          read_L1I_L2;
    logic [TW-1:0] tag_L1I_L2;
    logic [IW-1:0] index_L1I_L2;
    logic          ready_L2_L1I;
    logic [DW-1:0] read_data_L2_L1I;
    logic          read_L1_L2, write_L1_L2;
    logic [TW-1:0] tag_L1_L2, write_tag_L1_L2;
    logic [IW-1:0] index_L1_L2, write_index_L1_L2;
    logic [DW-1:0] write_data_L1_L2;
    logic          ready_L2_L1;
    logic [DW-1:0] read_data_L2_L1;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: who currently owns the L2 port (0 nobody, 1 L1D, 2 L1I),
    // whether we are in the post-completion dead cycle, who was served last,
    // and whether the last L1D service was a writeback.
    int m_owner;
    bit m_gap, m_last_d, m_lock;

    l1_l2_arbiter #(.TNUM2(TW), .INUM2(IW), .BIT_WIDTH_low(DW)) dut (
        .clk(clk), .nrst(nrst),
        .read_L1D_L2(read_L1D_L2), .write_L1D_L2(write_L1D_L2),
        .tag_L1D_L2(tag_L1D_L2), .index_L1D_L2(index_L1D_L2),
        .write_tag_L1D_L2(write_tag_L1D_L2), .write_index_L1D_L2(write_index_L1D_L2),
        .write_data_L1D_L2(write_data_L1D_L2),
        .ready_L2_L1D(ready_L2_L1D), .read_data_L2_L1D(read_data_L2_L1D),
        .read_L1I_L2(read_L1I_L2), .tag_L1I_L2(tag_L1I_L2), .index_L1I_L2(index_L1I_L2),
        .ready_L2_L1I(ready_L2_L1I), .read_data_L2_L1I(read_data_L2_L1I),
        .read_L1_L2(read_L1_L2), .write_L1_L2(write_L1_L2),
        .tag_L1_L2(tag_L1_L2), .index_L1_L2(index_L1_L2),
        .write_tag_L1_L2(write_tag_L1_L2), .write_index_L1_L2(write_index_L1_L2),
        .write_data_L1_L2(write_data_L1_L2),
        .ready_L2_L1(ready_L2_L1), .read_data_L2_L1(read_data_L2_L1)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rand_line();
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner  = 0;
        m_gap    = 1'b0;
        m_last_d = 1'b0;
        m_lock   = 1'b0;
    endtask

    task automatic model_clock();
        bit dreq;
        dreq = read_L1D_L2 | write_L1D_L2;
        if (m_gap) begin
            m_gap = 1'b0;
        end else if (m_owner != 0) begin
            if (ready_L2_L1) begin
                m_last_d = (m_owner == 1);
                m_lock   = (m_owner == 1) && write_L1D_L2;
                m_owner  = 0;
                m_gap    = 1'b1;
            end
        end else if (m_lock && read_L1D_L2) begin
            m_owner = 1;
        end else if (dreq && read_L1I_L2) begin
            m_owner = m_last_d ? 2 : 1;
        end else if (dreq) begin
            m_owner = 1;
        end else if (read_L1I_L2) begin
            m_owner = 2;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic          e_rd, e_wr, e_rdy_d, e_rdy_i;
        logic [TW-1:0] e_tag, e_wtag;
        logic [IW-1:0] e_idx, e_widx;
        logic [DW-1:0] e_wdata, e_dat_d, e_dat_i;
        e_rd = 0; e_wr = 0; e_rdy_d = 0; e_rdy_i = 0;
        e_tag = '0; e_wtag = '0; e_idx = '0; e_widx = '0;
        e_wdata = '0; e_dat_d = '0; e_dat_i = '0;
        if (m_owner == 1) begin
            e_rd    = read_L1D_L2 && !write_L1D_L2;
            e_wr    = write_L1D_L2;
            e_tag   = tag_L1D_L2;
            e_idx   = index_L1D_L2;
            e_wtag  = write_tag_L1D_L2;
            e_widx  = write_index_L1D_L2;
            e_wdata = write_data_L1D_L2;
            e_rdy_d = ready_L2_L1;
            e_dat_d = read_data_L2_L1;
        end else if (m_owner == 2) begin
            e_rd    = read_L1I_L2;
            e_tag   = tag_L1I_L2;
            e_idx   = index_L1I_L2;
            e_rdy_i = ready_L2_L1;
            e_dat_i = read_data_L2_L1;
        end
        chk({tag, ".read_L1_L2"}, DW'(read_L1_L2), DW'(e_rd));
        chk({tag, ".write_L1_L2"}, DW'(write_L1_L2), DW'(e_wr));
        chk({tag, ".tag_L1_L2"}, DW'(tag_L1_L2), DW'(e_tag));
        chk({tag, ".index_L1_L2"}, DW'(index_L1_L2), DW'(e_idx));
        chk({tag, ".write_tag_L1_L2"}, DW'(write_tag_L1_L2), DW'(e_wtag));
        chk({tag, ".write_index_L1_L2"}, DW'(write_index_L1_L2), DW'(e_widx));
        chk({tag, ".write_data_L1_L2"}, write_data_L1_L2, e_wdata);
        chk({tag, ".ready_L2_L1D"}, DW'(ready_L2_L1D), DW'(e_rdy_d));
        chk({tag, ".read_data_L2_L1D"}, read_data_L2_L1D, e_dat_d);
        chk({tag, ".ready_L2_L1I"}, DW'(ready_L2_L1I), DW'(e_rdy_i));
        chk({tag, ".read_data_L2_L1I"}, read_data_L2_L1I, e_dat_i);
    endtask

    // Called just after a falling edge with inputs already applied: checks the
    // combinational outputs, then advances the model across the rising edge.
    task automatic tick(input string tag);
        #1 check_outputs(tag);
        @(posedge clk);
        if (!nrst) model_reset();
        else       model_clock();
        @(negedge clk);
    endtask

    initial begin
        nrst = 0;
        read_L1D_L2 = 1; write_L1D_L2 = 0; read_L1I_L2 = 1;
        tag_L1D_L2 = 18'h11111; index_L1D_L2 = 8'h1D;
        write_tag_L1D_L2 = 18'h22222; write_index_L1D_L2 = 8'h2D;
        write_data_L1D_L2 = rand_line();
        tag_L1I_L2 = 18'h33333; index_L1I_L2 = 8'h3C;
        ready_L2_L1 = 1; read_data_L2_L1 = rand_line();
        model_reset();
        @(negedge clk);
        tick("reset");
        chk("reset_ready_d", DW'(ready_L2_L1D), '0);

        // Both fills pending from reset: L1D wins the first tie, L1I follows.
        nrst = 1; ready_L2_L1 = 0;
        tick("r042_idle");
        #1 chk("r042_rd", DW'(read_L1_L2), DW'(1'b1));
        chk("r042_tag", DW'(tag_L1_L2), DW'(18'h11111));
        tick("r042_grant_d");
        ready_L2_L1 = 1; read_data_L2_L1 = rand_line();
        #1 chk("r042_ready_d", DW'(ready_L2_L1D), DW'(1'b1));
        tick("r042_done_d");
        ready_L2_L1 = 0; read_L1D_L2 = 0;
        tick("r042_gap");
        tick("r042_idle2");
        #1 chk("r042_tag_i", DW'(tag_L1_L2), DW'(18'h33333));
        tick("r042_grant_i");
        ready_L2_L1 = 1; read_data_L2_L1 = rand_line();
        tick("r042_done_i");

        // Writeback+refill on L1D stays atomic against a pending L1I fill.
        ready_L2_L1 = 0;
        read_L1D_L2 = 1; write_L1D_L2 = 1;
        tag_L1D_L2 = 18'h01234; write_tag_L1D_L2 = 18'h00ABC;
        tick("r043_gap");
        tick("r043_idle");
        #1 chk("r043_wr", DW'(write_L1_L2), DW'(1'b1));
        chk("r043_rd", DW'(read_L1_L2), DW'(1'b0));
        chk("r043_wtag", DW'(write_tag_L1_L2), DW'(18'h00ABC));
        tick("r043_grant_w");
        ready_L2_L1 = 1; read_data_L2_L1 = rand_line();
        tick("r043_done_w");
        ready_L2_L1 = 0; write_L1D_L2 = 0;
        tick("r043_gap2");
        tick("r043_idle2");
        #1 chk("r043_rd2", DW'(read_L1_L2), DW'(1'b1));
        chk("r043_tag2", DW'(tag_L1_L2), DW'(18'h01234));
        tick("r043_grant_r");
        ready_L2_L1 = 1; read_data_L2_L1 = rand_line();
        tick("r043_done_r");
        ready_L2_L1 = 0; read_L1D_L2 = 0;
        tick("r044_gap");
        tick("r044_idle");

        // L1I fill returns a recognisable pattern; L1D sees nothing.
        ready_L2_L1 = 1;
        read_data_L2_L1 = {64{8'hA5}};
        #1 chk("r044_data_i", read_data_L2_L1I, {64{8'hA5}});
        chk("r044_ready_d", DW'(ready_L2_L1D), '0);
        tick("r044_done_i");
        ready_L2_L1 = 0; read_L1I_L2 = 0;
        tick("r045_gap");
        tick("r045_idle");

        // A stray L2 ready in IDLE must not surface or disturb the state.
        ready_L2_L1 = 1;
        #1 chk("r045_ready_d", DW'(ready_L2_L1D), '0);
        chk("r045_ready_i", DW'(ready_L2_L1I), '0);
        tick("r045_stray");
        ready_L2_L1 = 0; read_L1I_L2 = 1; read_L1D_L2 = 1;
        tick("r045_idle2");
        #1 chk("r045_granted", DW'(read_L1_L2), DW'(1'b1));
        tick("r046_grant");

        // Reset asserted mid-transaction clears outputs without a clock edge.
        ready_L2_L1 = 1;
        nrst = 0;
        model_reset();
        #1 chk("r046_rst_rd", DW'(read_L1_L2), '0);
        chk("r046_rst_ready", DW'(ready_L2_L1D | ready_L2_L1I), '0);
        tick("r046_rst");
        nrst = 1; ready_L2_L1 = 0;
        tick("r046_idle");
        #1 chk("r046_tie_d", DW'(tag_L1_L2), DW'(tag_L1D_L2));
        tick("r046_grant_d");

        // Randomized traffic against the model, including level drops while
        // granted, stray readies and occasional resets.
        for (int n = 0; n < 600; n++) begin
            nrst               = ($urandom_range(0, 79) != 0);
            read_L1D_L2        = ($urandom_range(0, 2) != 0);
            write_L1D_L2       = ($urandom_range(0, 3) == 0);
            read_L1I_L2        = ($urandom_range(0, 2) != 0);
            tag_L1D_L2         = TW'($urandom);
            index_L1D_L2       = IW'($urandom);
            write_tag_L1D_L2   = TW'($urandom);
            write_index_L1D_L2 = IW'($urandom);
            write_data_L1D_L2  = rand_line();
            tag_L1I_L2         = TW'($urandom);
            index_L1I_L2       = IW'($urandom);
            ready_L2_L1        = ($urandom_range(0, 2) == 0);
            read_data_L2_L1    = rand_line();
            if (!nrst) model_reset();
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
